// File: rtl/cail_pkg.sv
// Shared types and defaults for the calibration parameter write-back path.
// State encoding is one-hot; the DONE/ERR states emit the completion pulses on the way back to IDLE.
package cail_pkg;

  typedef enum logic [6:0] {
    ST_IDLE = 7'b0000001,
    ST_LOAD = 7'b0000010,
    ST_REQ  = 7'b0000100,
    ST_SEND = 7'b0001000,
    ST_TWR  = 7'b0010000,
    ST_DONE = 7'b0100000,
    ST_ERR  = 7'b1000000
  } state_t;

  localparam logic [7:0] EEPROM_ID = 8'hA0;

  localparam int DEF_NUM_BYTES  = 192;
  localparam int DEF_PAGE_BYTES = 8;
  localparam int DEF_T_WR       = 250_000;
  localparam int DEF_RAM_LAT    = 2;
  localparam int DEF_MAX_RETRY  = 3;

  // Bytes in the page starting at the current base: a full page, or whatever is left.
  function automatic logic [9:0] page_len(input logic [9:0] remaining, input logic [9:0] page);
    return (remaining < page) ? remaining : page;
  endfunction

endpackage

// File: rtl/cail_page_buf.sv
// Page staging buffer: one capture write port fed from the RAM pipeline, one indexed read port
// feeding the IIC write data. Contents are don't-care after reset, so no reset is applied.
module cail_page_buf #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cail_param_save.sv
// Copies the parameter RAM image into the EEPROM page by page through the iic_ctrl write port,
// retrying NACKed pages from the local buffer and waiting out the EEPROM write cycle between pages.
//
// state | meaning
// IDLE  | waiting for save_req
// LOAD  | reading one page from RAM into the page buffer
// REQ   | one-cycle write request to iic_ctrl
// SEND  | feeding bytes on ee_w_valid, waiting for ee_wr_done
// TWR   | EEPROM internal write-cycle wait
// DONE  | save_done pulse, back to IDLE
// ERR   | save_err pulse, back to IDLE
module cail_param_save
  import cail_pkg::*;
#(
  parameter int NUM_BYTES  = DEF_NUM_BYTES,
  parameter int PAGE_BYTES = DEF_PAGE_BYTES,
  parameter int T_WR       = DEF_T_WR,
  parameter int RAM_LAT    = DEF_RAM_LAT,
  parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        save_req,
  output logic        busy,
  output logic        save_done,
  output logic        save_err,
  output logic [9:0]  ram_r_addr,
  input  logic [7:0]  ram_r_data,
  output logic        ee_w_req,
  output logic [15:0] ee_reg_addr,
  output logic [15:0] ee_w_num,
  output logic [7:0]  ee_w_data,
  input  logic        ee_w_valid,
  input  logic        ee_wr_done,
  input  logic        ee_ack
);

  localparam int          IDX_W    = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
  localparam int          CNT_W    = $clog2(PAGE_BYTES + 1);
  localparam logic [9:0]  TOTAL    = 10'(NUM_BYTES);
  localparam logic [9:0]  PAGE     = 10'(PAGE_BYTES);
  localparam logic [17:0] TWR_LOAD = 18'(T_WR - 1);

  state_t state, state_nxt;

  logic [9:0]       base;
  logic [9:0]       n_full;
  logic [9:0]       page_end;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] cap_cnt;
  logic [IDX_W-1:0] widx;
  logic [7:0]       retry;
  logic [17:0]      twr_cnt;
  logic [9:0]       addr_q;
  logic [RAM_LAT-1:0] vld;
  logic [IDX_W-1:0]   pidx [RAM_LAT];
  logic [7:0]       buf_rd;

  logic issue;
  logic capture;
  logic load_last;
  logic twr_end;
  logic retry_ok;

  assign n_full    = page_len(TOTAL - base, PAGE);
  assign n         = CNT_W'(n_full);
  assign page_end  = base + n_full;
  assign issue     = (state == ST_LOAD) && (rd_cnt < n);
  assign capture   = (state == ST_LOAD) && vld[RAM_LAT-1];
  assign load_last = capture && (cap_cnt == n - CNT_W'(1));
  assign twr_end   = (twr_cnt == 18'd0);
  assign retry_ok  = (retry < 8'(MAX_RETRY));

  // The address is presented combinationally in the issuing cycle so the valid pipeline is exactly RAM_LAT deep.
  assign ram_r_addr = issue ? (base + 10'(rd_cnt)) : addr_q;

  cail_page_buf #(
    .DEPTH (PAGE_BYTES),
    .IDX_W (IDX_W)
  ) u_page_buf (
    .clk     (clk),
    .wr_en   (capture),
    .wr_idx  (pidx[RAM_LAT-1]),
    .wr_data (ram_r_data),
    .rd_idx  (widx),
    .rd_data (buf_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (save_req) state_nxt = ST_LOAD;
      ST_LOAD: if (load_last) state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_SEND;
      ST_SEND: begin
        if (ee_wr_done) begin
          if (ee_ack)        state_nxt = ST_TWR;
          else if (retry_ok) state_nxt = ST_REQ;
          else               state_nxt = ST_ERR;
        end
      end
      ST_TWR:  if (twr_end) state_nxt = (page_end == TOTAL) ? ST_DONE : ST_LOAD;
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = state inside {ST_LOAD, ST_REQ, ST_SEND, ST_TWR};
    save_done = (state == ST_DONE);
    save_err  = (state == ST_ERR);
    ee_w_req  = (state == ST_REQ);
    ee_w_data = (state inside {ST_REQ, ST_SEND}) ? buf_rd : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base        <= '0;
      retry       <= '0;
      rd_cnt      <= '0;
      cap_cnt     <= '0;
      widx        <= '0;
      twr_cnt     <= '0;
      addr_q      <= '0;
      vld         <= '0;
      ee_reg_addr <= '0;
      ee_w_num    <= '0;
    end else begin
      vld[0]  <= issue;
      pidx[0] <= IDX_W'(rd_cnt);
      for (int i = 1; i < RAM_LAT; i++) begin
        vld[i]  <= vld[i-1];
        pidx[i] <= pidx[i-1];
      end

      if (issue) begin
        addr_q <= base + 10'(rd_cnt);
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (capture) cap_cnt <= cap_cnt + CNT_W'(1);
      if (state != ST_LOAD) begin
        rd_cnt  <= '0;
        cap_cnt <= '0;
      end

      if (state == ST_IDLE && save_req) begin
        base  <= '0;
        retry <= '0;
      end

      // A retry re-enters REQ with the same base, so the buffer is resent without touching RAM.
      if (state_nxt == ST_REQ) begin
        ee_reg_addr <= {6'b0, base};
        ee_w_num    <= 16'(n);
        widx        <= '0;
      end else if (state == ST_SEND && ee_w_valid && !ee_wr_done
                   && (CNT_W'(widx) < n - CNT_W'(1))) begin
        widx <= widx + IDX_W'(1);
      end

      if (state == ST_SEND && ee_wr_done && !ee_ack && retry_ok) retry <= retry + 8'd1;

      if (state == ST_SEND && ee_wr_done && ee_ack) twr_cnt <= TWR_LOAD;
      else if (state == ST_TWR && !twr_end)         twr_cnt <= twr_cnt - 18'd1;

      if (state == ST_TWR && twr_end) begin
        base  <= page_end;
        retry <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cail_param_save.sv
// Directed bench: three DUT instances (16 bytes/lat 2, 13 bytes/lat 1, 13 bytes/lat 3) with a RAM
// model returning addr+0x10 and a simple iic_ctrl model with a configurable NACK policy.
module tb_cail_param_save;

  localparam int NINST = 3;
  localparam int NB  [NINST] = '{16, 13, 13};
  localparam int LAT [NINST] = '{2, 1, 3};
  localparam int TWR = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NINST-1:0] save_req = '0;
  logic [NINST-1:0] busy_v, done_v, err_v;
  int  nack_set [NINST] = '{0, 0, 0};
  bit  nack_all [NINST] = '{0, 0, 0};
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int L = LAT[g];

    logic [9:0]  ram_r_addr;
    logic [7:0]  ram_r_data;
    logic        ee_w_req;
    logic [15:0] ee_reg_addr, ee_w_num;
    logic [7:0]  ee_w_data;
    logic        ee_w_valid, ee_wr_done, ee_ack;

    logic [9:0]  apipe [L];
    int          req_cnt, done_cnt, err_cnt, bad_bytes, addr_chg, nack_left, mstate, bcnt;
    int          req_cyc [8];
    int          done_cyc [8];
    logic [15:0] req_addr [8];
    logic [15:0] req_num [8];
    logic [15:0] cur_addr, cur_num;
    logic [9:0]  prev_addr;
    logic [7:0]  img [16];
    logic [7:0]  burst [8];

    cail_param_save #(
      .NUM_BYTES (NB[g]), .PAGE_BYTES (8), .T_WR (TWR), .RAM_LAT (L), .MAX_RETRY (3)
    ) u_dut (
      .clk (clk), .rst (rst), .save_req (save_req[g]),
      .busy (busy_v[g]), .save_done (done_v[g]), .save_err (err_v[g]),
      .ram_r_addr (ram_r_addr), .ram_r_data (ram_r_data),
      .ee_w_req (ee_w_req), .ee_reg_addr (ee_reg_addr), .ee_w_num (ee_w_num),
      .ee_w_data (ee_w_data), .ee_w_valid (ee_w_valid),
      .ee_wr_done (ee_wr_done), .ee_ack (ee_ack)
    );

    // RAM model: data for the address seen in cycle t appears in cycle t+L.
    always @(posedge clk) begin
      apipe[0] <= ram_r_addr;
      for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
    assign ram_r_data = apipe[L-1][7:0] + 8'h10;

    always @(posedge clk) begin
      if (rst) begin
        ee_w_valid <= 1'b0; ee_wr_done <= 1'b0; ee_ack <= 1'b0;
        req_cnt <= 0; done_cnt <= 0; err_cnt <= 0; bad_bytes <= 0; addr_chg <= 0;
        mstate <= 0; bcnt <= 0; prev_addr <= '0; nack_left <= nack_set[g];
        for (int i = 0; i < 16; i++) img[i] <= 8'h00;
      end else begin
        if (done_v[g]) done_cnt <= done_cnt + 1;
        if (err_v[g])  err_cnt  <= err_cnt + 1;
        if (ram_r_addr != prev_addr) addr_chg <= addr_chg + 1;
        prev_addr <= ram_r_addr;
        case (mstate)
          0: if (ee_w_req) begin
               if (req_cnt < 8) begin
                 req_addr[req_cnt] <= ee_reg_addr;
                 req_num[req_cnt]  <= ee_w_num;
                 req_cyc[req_cnt]  <= cyc;
               end
               req_cnt  <= req_cnt + 1;
               cur_addr <= ee_reg_addr;
               cur_num  <= ee_w_num;
               bcnt     <= 0;
               mstate   <= 1;
             end
          1: begin ee_w_valid <= 1'b1; mstate <= 2; end
          2: begin
               ee_w_valid <= 1'b0;
               burst[bcnt] <= ee_w_data;
               if (ee_w_data !== 8'(cur_addr + 16'(bcnt)) + 8'h10) bad_bytes <= bad_bytes + 1;
               if (bcnt >= int'(cur_num) - 1) mstate <= 3;
               else begin bcnt <= bcnt + 1; mstate <= 1; end
             end
          3: begin
               ee_wr_done <= 1'b1;
               if (nack_all[g]) ee_ack <= 1'b0;
               else if (nack_left > 0) begin ee_ack <= 1'b0; nack_left <= nack_left - 1; end
               else ee_ack <= 1'b1;
               mstate <= 4;
             end
          default: begin
               ee_wr_done <= 1'b0;
               ee_ack     <= 1'b0;
               if (req_cnt >= 1 && req_cnt <= 8) done_cyc[req_cnt-1] <= cyc;
               if (ee_ack) for (int i = 0; i < int'(cur_num); i++) img[int'(cur_addr) + i] <= burst[i];
               mstate <= 0;
             end
        endcase
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_req(input int g);
    @(negedge clk); save_req[g] = 1'b1;
    @(negedge clk); save_req[g] = 1'b0;
  endtask

  task automatic wait_end(input int g, input string name);
    int n;
    n = 0;
    while (!(done_v[g] || err_v[g]) && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL %s end_timeout: no save_done/save_err within 2000 cycles", name); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy_v, done_v, err_v} !== '0) begin errors++; $display("FAIL reset flags got %b exp 0", {busy_v, done_v, err_v}); end
    checks++; if (g_dut[0].ee_w_req !== 1'b0 || g_dut[0].ram_r_addr !== 10'd0) begin errors++; $display("FAIL reset req/addr got %b/%0d exp 0/0", g_dut[0].ee_w_req, g_dut[0].ram_r_addr); end
    checks++; if ({g_dut[0].ee_reg_addr, g_dut[0].ee_w_num, g_dut[0].ee_w_data} !== 40'd0) begin errors++; $display("FAIL reset ee_outputs got %h exp 0", {g_dut[0].ee_reg_addr, g_dut[0].ee_w_num, g_dut[0].ee_w_data}); end
    rst = 1'b0;
  endtask

  task automatic test_two_pages();
    int bad, gap;
    do_reset(); pulse_req(0);
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL two_pages busy_after_req got %b exp 1", busy_v[0]); end
    wait_end(0, "two_pages");
    checks++; if (g_dut[0].req_cnt !== 2) begin errors++; $display("FAIL two_pages req_cnt got %0d exp 2", g_dut[0].req_cnt); end
    checks++; if (g_dut[0].req_addr[0] !== 16'd0 || g_dut[0].req_num[0] !== 16'd8) begin errors++; $display("FAIL two_pages burst1 addr/num got %0d/%0d exp 0/8", g_dut[0].req_addr[0], g_dut[0].req_num[0]); end
    checks++; if (g_dut[0].req_addr[1] !== 16'd8 || g_dut[0].req_num[1] !== 16'd8) begin errors++; $display("FAIL two_pages burst2 addr/num got %0d/%0d exp 8/8", g_dut[0].req_addr[1], g_dut[0].req_num[1]); end
    checks++; if (g_dut[0].bad_bytes !== 0) begin errors++; $display("FAIL two_pages bad_bytes got %0d exp 0", g_dut[0].bad_bytes); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (g_dut[0].img[i] !== 8'(i + 16)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL two_pages image wrong_bytes got %0d exp 0", bad); end
    // TWR wait, then at least 8 LOAD cycles and the REQ cycle before the next request.
    gap = g_dut[0].req_cyc[1] - g_dut[0].done_cyc[0];
    checks++; if (gap < TWR + 9 || gap > TWR + 20) begin errors++; $display("FAIL two_pages twr_gap got %0d exp %0d..%0d", gap, TWR + 9, TWR + 20); end
    checks++; if (g_dut[0].done_cnt !== 1 || g_dut[0].err_cnt !== 0) begin errors++; $display("FAIL two_pages done/err got %0d/%0d exp 1/0", g_dut[0].done_cnt, g_dut[0].err_cnt); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL two_pages busy_end got %b exp 0", busy_v[0]); end
    checks++; if (g_dut[0].addr_chg !== 15) begin errors++; $display("FAIL two_pages ram_addr_changes got %0d exp 15", g_dut[0].addr_chg); end
  endtask

  task automatic test_partial();
    int bad;
    do_reset(); pulse_req(1);
    wait_end(1, "partial");
    repeat (30) @(negedge clk);
    checks++; if (g_dut[1].req_cnt !== 2) begin errors++; $display("FAIL partial req_cnt got %0d exp 2", g_dut[1].req_cnt); end
    checks++; if (g_dut[1].req_addr[1] !== 16'd8 || g_dut[1].req_num[1] !== 16'd5) begin errors++; $display("FAIL partial burst2 addr/num got %0d/%0d exp 8/5", g_dut[1].req_addr[1], g_dut[1].req_num[1]); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (g_dut[1].img[i] !== ((i < 13) ? 8'(i + 16) : 8'h00)) bad++;
    checks++; if (bad !== 0 || g_dut[1].bad_bytes !== 0) begin errors++; $display("FAIL partial image wrong_bytes got %0d/%0d exp 0/0", bad, g_dut[1].bad_bytes); end
    checks++; if (g_dut[1].done_cnt !== 1) begin errors++; $display("FAIL partial done_count got %0d exp 1", g_dut[1].done_cnt); end
    checks++; if (g_dut[1].addr_chg !== 12) begin errors++; $display("FAIL partial ram_addr_changes got %0d exp 12", g_dut[1].addr_chg); end
  endtask

  task automatic test_lat3();
    int bad;
    do_reset(); pulse_req(2);
    wait_end(2, "lat3");
    bad = 0;
    for (int i = 0; i < 16; i++) if (g_dut[2].img[i] !== ((i < 13) ? 8'(i + 16) : 8'h00)) bad++;
    checks++; if (bad !== 0 || g_dut[2].bad_bytes !== 0) begin errors++; $display("FAIL lat3 image wrong_bytes got %0d/%0d exp 0/0", bad, g_dut[2].bad_bytes); end
    checks++; if (g_dut[2].req_cnt !== 2 || g_dut[2].req_num[1] !== 16'd5) begin errors++; $display("FAIL lat3 req_cnt/num2 got %0d/%0d exp 2/5", g_dut[2].req_cnt, g_dut[2].req_num[1]); end
    checks++; if (g_dut[2].done_cnt !== 1) begin errors++; $display("FAIL lat3 done_count got %0d exp 1", g_dut[2].done_cnt); end
  endtask

  task automatic test_retry();
    int bad;
    nack_set[0] = 2;
    do_reset(); pulse_req(0);
    wait_end(0, "retry");
    checks++; if (g_dut[0].req_cnt !== 4) begin errors++; $display("FAIL retry req_cnt got %0d exp 4", g_dut[0].req_cnt); end
    checks++; if ({g_dut[0].req_addr[0], g_dut[0].req_addr[1], g_dut[0].req_addr[2], g_dut[0].req_addr[3]} !== {16'd0, 16'd0, 16'd0, 16'd8}) begin errors++; $display("FAIL retry req_addrs got %0d,%0d,%0d,%0d exp 0,0,0,8", g_dut[0].req_addr[0], g_dut[0].req_addr[1], g_dut[0].req_addr[2], g_dut[0].req_addr[3]); end
    checks++; if (g_dut[0].bad_bytes !== 0) begin errors++; $display("FAIL retry bad_bytes got %0d exp 0", g_dut[0].bad_bytes); end
    checks++; if (g_dut[0].addr_chg !== 15) begin errors++; $display("FAIL retry ram_addr_changes got %0d exp 15", g_dut[0].addr_chg); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (g_dut[0].img[i] !== 8'(i + 16)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL retry image wrong_bytes got %0d exp 0", bad); end
    checks++; if (g_dut[0].done_cnt !== 1 || g_dut[0].err_cnt !== 0) begin errors++; $display("FAIL retry done/err got %0d/%0d exp 1/0", g_dut[0].done_cnt, g_dut[0].err_cnt); end
    nack_set[0] = 0;
  endtask

  task automatic test_abort();
    int bad;
    nack_all[0] = 1'b1;
    do_reset(); pulse_req(0);
    wait_end(0, "abort");
    checks++; if (g_dut[0].req_cnt !== 4) begin errors++; $display("FAIL abort req_cnt got %0d exp 4", g_dut[0].req_cnt); end
    checks++; if (g_dut[0].err_cnt !== 1 || g_dut[0].done_cnt !== 0) begin errors++; $display("FAIL abort err/done got %0d/%0d exp 1/0", g_dut[0].err_cnt, g_dut[0].done_cnt); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL abort busy_end got %b exp 0", busy_v[0]); end
    checks++; if (g_dut[0].addr_chg !== 7) begin errors++; $display("FAIL abort ram_addr_changes got %0d exp 7", g_dut[0].addr_chg); end
    bad = 0;
    for (int i = 0; i < 4; i++) if (g_dut[0].req_addr[i] !== 16'd0) bad++;
    for (int i = 0; i < 16; i++) if (g_dut[0].img[i] !== 8'h00) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort addr/image wrong_entries got %0d exp 0", bad); end
    nack_all[0] = 1'b0;
  endtask

  task automatic test_busy_ignore();
    do_reset();
    @(negedge clk); save_req[0] = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL busy_ignore busy_while_held got %b exp 1", busy_v[0]); end
    save_req[0] = 1'b0;
    wait_end(0, "busy_ignore");
    repeat (40) @(negedge clk);
    checks++; if (g_dut[0].req_cnt !== 2 || g_dut[0].done_cnt !== 1) begin errors++; $display("FAIL busy_ignore req/done got %0d/%0d exp 2/1", g_dut[0].req_cnt, g_dut[0].done_cnt); end
  endtask

  task automatic test_rst_mid_send();
    int n;
    do_reset(); pulse_req(0);
    n = 0;
    while (!(g_dut[0].req_cnt == 2 && g_dut[0].ee_w_valid) && n < 500) begin @(negedge clk); n++; end
    checks++; if (n >= 500) begin errors++; $display("FAIL rst_mid second_send_timeout got %0d cycles exp <500", n); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy_v[0], done_v[0], err_v[0], g_dut[0].ee_w_req} !== 4'b0) begin errors++; $display("FAIL rst_mid flags got %b exp 0000", {busy_v[0], done_v[0], err_v[0], g_dut[0].ee_w_req}); end
    checks++; if ({g_dut[0].ram_r_addr, g_dut[0].ee_reg_addr, g_dut[0].ee_w_num, g_dut[0].ee_w_data} !== 50'd0) begin errors++; $display("FAIL rst_mid outputs got %h exp 0", {g_dut[0].ram_r_addr, g_dut[0].ee_reg_addr, g_dut[0].ee_w_num, g_dut[0].ee_w_data}); end
    rst = 1'b0;
    pulse_req(0);
    wait_end(0, "rst_mid");
    checks++; if (g_dut[0].req_addr[0] !== 16'd0 || g_dut[0].req_cnt !== 2) begin errors++; $display("FAIL rst_mid restart addr/req_cnt got %0d/%0d exp 0/2", g_dut[0].req_addr[0], g_dut[0].req_cnt); end
    checks++; if (g_dut[0].done_cnt !== 1) begin errors++; $display("FAIL rst_mid done_count got %0d exp 1", g_dut[0].done_cnt); end
  endtask

  initial begin
    test_reset();
    test_two_pages();
    test_partial();
    test_lat3();
    test_retry();
    test_abort();
    test_busy_ignore();
    test_rst_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
